hw_msg_assembler: RTL



---
 rtl/hw_msg_if.sv | 25 ++
 rtl/hw_msg_assembler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hw_msg_if.sv
// Software handshake and message-stream bundle for hw_msg_assembler.
// slave: the assembler side; master: software/consumer side.
interface hw_msg_if #(
    parameter int WORDS_PER_MSG = 4,
    parameter int FIFO_DEPTH    = 4
);
    logic [1:0]                      to_hw_sig;
    logic [7:0]                      to_hw_port;
    logic [1:0]                      to_sw_sig;
    logic [8*WORDS_PER_MSG-1:0]      msg_data;
    logic                            msg_valid;
    logic                            msg_ready;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;
    logic                            msg_err;

    modport slave (
        input  to_hw_sig, to_hw_port, msg_ready,
        output to_sw_sig, msg_data, msg_valid, fifo_count, msg_err
    );

    modport master (
        output to_hw_sig, to_hw_port, msg_ready,
        input  to_sw_sig, msg_data, msg_valid, fifo_count, msg_err
    );
endinterface

// File: rtl/hw_msg_assembler.sv
// Byte-wise software handshake -> message assembly -> FIFO -> valid/ready stream.
// Optional HW_MSG_CHECKSUM_EN: last byte must equal XOR of the preceding bytes.
module hw_msg_assembler #(
    parameter int WORDS_PER_MSG = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     reset,
    hw_msg_if.slave  bus
);
    localparam int IW = $clog2(WORDS_PER_MSG);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int MW = 8 * WORDS_PER_MSG;
    localparam logic [IW-1:0] LAST = IW'(WORDS_PER_MSG - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPT, ACK, REL} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [MW-9:0]       r_asm;
    logic [1:0]          r_sw;
    logic                r_err;
    logic [PW-1:0]       r_wr;
    logic [PW-1:0]       r_rd;
    logic [CW-1:0]       r_count;
    logic [MW-1:0]       r_mem [FIFO_DEPTH];

    logic                w_last;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_abort;
    logic                w_ok;
    logic                w_push;
    logic [MW-1:0]       w_msg;

    assign w_last  = (r_idx == LAST);
    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.msg_ready;
    assign w_abort = (bus.to_hw_sig == 2'd3) && (r_state != REL);
    assign w_msg   = {bus.to_hw_port, r_asm};

`ifdef HW_MSG_CHECKSUM_EN
    logic [7:0] w_csum;
    always_comb begin
        w_csum = bus.to_hw_port;
        for (int i = 0; i < WORDS_PER_MSG - 1; i++)
            w_csum = w_csum ^ r_asm[8*i +: 8];
    end
    assign w_ok = (w_csum == 8'h00);
`else
    assign w_ok = 1'b1;
`endif

    assign w_push = (r_state == CAPT) && w_last && !w_abort && w_ok;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= w_msg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_asm   <= '0;
            r_sw    <= 2'd0;
            r_err   <= 1'b0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + PW'(1);
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);

            if (w_abort) begin
                r_err   <= 1'b1;
                r_idx   <= '0;
                r_sw    <= 2'd0;
                r_state <= REL;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        // The last byte waits here until the queue has room.
                        if (bus.to_hw_sig == 2'd2 && !(w_last && w_full))
                            r_state <= CAPT;
                    end
                    CAPT: begin
                        if (w_last) begin
                            r_idx <= '0;
                            r_sw  <= w_ok ? 2'd3 : 2'd1;
                        end else begin
                            for (int i = 0; i < WORDS_PER_MSG - 1; i++)
                                if (r_idx == IW'(i))
                                    r_asm[8*i +: 8] <= bus.to_hw_port;
                            r_idx <= r_idx + IW'(1);
                            r_sw  <= 2'd2;
                        end
                        r_state <= ACK;
                    end
                    ACK: begin
                        if (bus.to_hw_sig == 2'd1) begin
                            r_sw    <= 2'd0;
                            r_state <= REL;
                        end
                    end
                    REL: begin
                        if (bus.to_hw_sig == 2'd0)
                            r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.to_sw_sig  = r_sw;
    assign bus.msg_valid  = !w_empty;
    assign bus.msg_data   = w_empty ? '0 : r_mem[r_rd];
    assign bus.fifo_count = r_count;
    assign bus.msg_err    = r_err;
endmodule
